tl_ul_mem_responder: RTL

- TileLink-UL-style slave-side responder that terminates A-channel requests from the processor's memory-stage master.
- Buffers requests in a small FIFO and executes them against an internal word-organised data memory.
- Returns AccessAck or AccessAckData on the D channel, with error flagging and a backpressure indication back to the master.
- Sits at the far end of the master's A/D interface; drop-in target for master-side load/store traffic.

---
 rtl/tl_ul_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL style slave responder: queues A-channel requests in a small FIFO,
// runs them serially against a word-organised memory and answers on the D channel.
module tl_ul_mem_responder #(
  parameter int A_CHANNEL_SIZE = 53,
  parameter int D_CHANNEL_SIZE = 43,
  parameter int MEM_DEPTH      = 256,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [A_CHANNEL_SIZE-1:0] a_channel,
  output logic                      d_valid,
  input  logic                      d_ready,
  output logic [D_CHANNEL_SIZE-1:0] d_channel,
  output logic                      d_error,
  output logic                      backpressureslave
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int MW = $clog2(MEM_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [A_CHANNEL_SIZE-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]             count_reg, count_next;
  logic                      bp_reg;
  logic [1:0]                state_reg;
  logic [A_CHANNEL_SIZE-1:0] work_reg;
  logic                      push, pop, fifo_full;

  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign a_ready   = reset && !fifo_full;
  assign push      = a_valid && a_ready;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);

  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      bp_reg     <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      bp_reg    <= (count_next >= CW'(FIFO_DEPTH - 1));
    end
  end

  assign backpressureslave = bp_reg;

  // Storage and head read carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= a_channel;
    if (pop)  work_reg <= fifo_mem[rd_ptr_reg];
  end

  logic [2:0]  op;
  logic [1:0]  size;
  logic [3:0]  mask;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [9:0]  word_idx;
  logic [MW-1:0] mem_idx;
  logic        op_legal, err, is_write, is_read;
  logic [3:0]  byte_en;
  logic [31:0] rdata;

  assign op       = work_reg[52:50];
  assign size     = work_reg[49:48];
  assign mask     = work_reg[47:44];
  assign addr     = work_reg[43:32];
  assign wdata    = work_reg[31:0];
  assign word_idx = addr[11:2];
  assign mem_idx  = word_idx[MW-1:0];

  assign op_legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
  assign err = !op_legal
            || ({22'd0, word_idx} >= MEM_DEPTH)
            || (size == 2'd3)
            || ((size == 2'd1) && addr[0])
            || ((size == 2'd2) && (addr[1:0] != 2'b00));

  assign is_write = (state_reg == EXEC) && !err && ((op == 3'd0) || (op == 3'd1));
  assign is_read  = (state_reg == EXEC) && !err && (op == 3'd4);

  // One RAM lane per byte so partial writes need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] rd_byte;

      assign byte_en[gi] = is_write && ((op == 3'd0) || mask[gi]);

      always_ff @(posedge clk) begin
        if (byte_en[gi]) lane_mem[mem_idx] <= wdata[8*gi +: 8];
        if (is_read)     rd_byte <= lane_mem[mem_idx];
      end

      assign rdata[8*gi +: 8] = rd_byte;
    end
  endgenerate

  logic       d_valid_reg, d_err_reg, d_data_en_reg;
  logic [2:0] d_op_reg;
  logic [1:0] d_size_reg;
  logic [5:0] d_addr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      d_valid_reg   <= 1'b0;
      d_err_reg     <= 1'b0;
      d_data_en_reg <= 1'b0;
      d_op_reg      <= 3'd0;
      d_size_reg    <= 2'd0;
      d_addr_reg    <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) state_reg <= EXEC;
        end
        EXEC: begin
          d_valid_reg   <= 1'b1;
          d_err_reg     <= err;
          d_data_en_reg <= is_read;
          d_op_reg      <= (op == 3'd4) ? 3'd1 : 3'd0;
          d_size_reg    <= size;
          d_addr_reg    <= addr[5:0];
          state_reg     <= RESP;
        end
        RESP: begin
          if (d_ready) begin
            d_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign d_valid   = d_valid_reg;
  assign d_error   = d_err_reg;
  assign d_channel = {d_op_reg, d_size_reg, d_addr_reg, d_data_en_reg ? rdata : 32'd0};

endmodule
